// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// pipe_ctrl_pkg : shared types and encodings for the pipeline hazard/interrupt controller
// Revision      : 1.0  initial release
//==============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    VECTOR = 2'd2
  } state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_VEC = 2'd2;
  localparam logic [1:0] PCSEL_EPC = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
//==============================================================================
// hazard_detect : combinational load-use compare between the ID sources and EX load
// Revision      : 1.0  initial release
//==============================================================================
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             use1_i,
  input  logic             use2_i,
  input  logic             ex_load_i,
  input  logic [REG_W-1:0] ex_dst_i,
  output logic             hazard_o
);

  logic dst_live;
  logic hit1;
  logic hit2;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign dst_live = ex_load_i && (ex_dst_i != '0);
  assign hit1     = use1_i && (rs1_i == ex_dst_i);
  assign hit2     = use2_i && (rs2_i == ex_dst_i);
  assign hazard_o = dst_live && (hit1 || hit2);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//==============================================================================
// pipe_ctrl : load-use stall, branch/reti redirect and interrupt drain/vector control
// Revision  : 1.0  initial release
//==============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 3,
  parameter logic [31:0] INT_VEC   = 32'h0000_0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_branch,
  input  logic             id_reti,
  input  logic [31:0]      id_pc_plus_4,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             int_req,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       pc_sel,
  output logic [31:0]      epc,
  output logic             int_ack
);

  localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYC - 1);

  if ((DRAIN_CYC < 1) || (DRAIN_CYC > 7)) begin : g_bad_drain
    $error("pipe_ctrl: DRAIN_CYC must be in 1..7");
  end
  if (INT_VEC[1:0] != 2'b00) begin : g_bad_vec
    $error("pipe_ctrl: INT_VEC must be word aligned");
  end

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        int_pend_q, int_pend_d;
  logic        int_en_q, int_en_d;
  logic [31:0] epc_q, epc_d;
  logic        hazard;

  hazard_detect u_hazard (
    .rs1_i     (id_rs1),
    .rs2_i     (id_rs2),
    .use1_i    (id_use1),
    .use2_i    (id_use2),
    .ex_load_i (ex_load),
    .ex_dst_i  (ex_dst),
    .hazard_o  (hazard)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    int_en_d    = int_en_q;
    epc_d       = epc_q;
    int_pend_d  = int_pend_q;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_sel      = PCSEL_SEQ;
    int_ack     = 1'b0;

    case (state_q)
      RUN: begin
        // Priority: stall > branch > reti > interrupt entry; lower ones retry later.
        if (hazard) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (id_branch) begin
          pc_sel      = PCSEL_BR;
          flush_if_id = 1'b1;
        end else if (id_reti) begin
          pc_sel      = PCSEL_EPC;
          flush_if_id = 1'b1;
          int_en_d    = 1'b1;
        end else if (int_pend_q) begin
          epc_d    = id_pc_plus_4;
          int_en_d = 1'b0;
          cnt_d    = CNT_INIT;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (cnt_q == 3'd0) begin
          state_d = VECTOR;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      VECTOR: begin
        pc_sel      = PCSEL_VEC;
        int_ack     = 1'b1;
        flush_if_id = 1'b1;
        state_d     = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (state_q == VECTOR) begin
      int_pend_d = 1'b0;
    end else if (int_req && int_en_q) begin
      int_pend_d = 1'b1;
    end

    // Suppress strobes while reset is held so an abandoned entry never acks.
    if (rst) begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      pc_sel      = PCSEL_SEQ;
      int_ack     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      int_pend_q <= 1'b0;
      int_en_q   <= 1'b1;
      epc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
      int_en_q   <= int_en_d;
      epc_q      <= epc_d;
    end
  end

  assign epc = epc_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//==============================================================================
// tb_pipe_ctrl : directed + randomized bench against a cycle-phase reference model
// Revision     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int unsigned D   = 3;
  localparam logic [31:0] VEC = 32'h0000_0010;

  logic        clk;
  logic        rst;
  logic [3:0]  id_rs1, id_rs2, ex_dst;
  logic        id_use1, id_use2, id_branch, id_reti, ex_load, int_req;
  logic [31:0] id_pc_plus_4;
  logic        stall_pc, stall_if_id, flush_if_id, flush_id_ex, int_ack;
  logic [1:0]  pc_sel;
  logic [31:0] epc;

  pipe_ctrl #(.DRAIN_CYC(D), .INT_VEC(VEC)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use1      (id_use1),
    .id_use2      (id_use2),
    .id_branch    (id_branch),
    .id_reti      (id_reti),
    .id_pc_plus_4 (id_pc_plus_4),
    .ex_load      (ex_load),
    .ex_dst       (ex_dst),
    .int_req      (int_req),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .pc_sel       (pc_sel),
    .epc          (epc),
    .int_ack      (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int acks  = 0;

  // Model: phase 0 = running, 1..D = n-th drain cycle, D+1 = vector cycle.
  int          m_phase = 0;
  bit          m_pend  = 1'b0;
  bit          m_en    = 1'b1;
  logic [31:0] m_epc   = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
    id_branch = 1'b0; id_reti = 1'b0; ex_load = 1'b0; ex_dst = 4'd0; int_req = 1'b0;
  endtask

  task automatic step();
    logic       haz;
    logic       e_spc, e_sif, e_fif, e_fex, e_ack;
    logic [1:0] e_pc;
    bit         entry;
    @(negedge clk);
    haz = ex_load && (ex_dst != 4'd0) &&
          ((id_use1 && id_rs1 == ex_dst) || (id_use2 && id_rs2 == ex_dst));
    {e_spc, e_sif, e_fif, e_fex, e_ack} = 5'b0;
    e_pc  = 2'd0;
    entry = 1'b0;
    if (!rst) begin
      if (m_phase == 0) begin
        if (haz)            {e_spc, e_sif, e_fex} = 3'b111;
        else if (id_branch) begin e_pc = 2'd1; e_fif = 1'b1; end
        else if (id_reti)   begin e_pc = 2'd3; e_fif = 1'b1; end
        else if (m_pend)    entry = 1'b1;
      end else if (m_phase <= int'(D)) begin
        {e_spc, e_fif, e_fex} = 3'b111;
      end else begin
        e_pc = 2'd2; e_ack = 1'b1; e_fif = 1'b1;
      end
    end
    check("stall_pc",    32'(stall_pc),    32'(e_spc));
    check("stall_if_id", 32'(stall_if_id), 32'(e_sif));
    check("flush_if_id", 32'(flush_if_id), 32'(e_fif));
    check("flush_id_ex", 32'(flush_id_ex), 32'(e_fex));
    check("pc_sel",      32'(pc_sel),      32'(e_pc));
    check("int_ack",     32'(int_ack),     32'(e_ack));
    check("epc",         epc,              m_epc);
    if (int_ack) acks++;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_pend = 1'b0; m_en = 1'b1; m_epc = 32'd0;
    end else begin
      if (m_phase == int'(D) + 1) m_pend = 1'b0;
      else if (int_req && m_en)   m_pend = 1'b1;
      if (m_phase == 0 && !haz && !id_branch && id_reti) m_en = 1'b1;
      if (entry) begin
        m_epc = id_pc_plus_4; m_en = 1'b0; m_phase = 1;
      end else if (m_phase > 0) begin
        m_phase = (m_phase == int'(D) + 1) ? 0 : m_phase + 1;
      end
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    idle();
    id_pc_plus_4 = 32'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    steps(2);
    rst = 1'b0;
    steps(1);

    // Load-use on rs1, then released
    ex_load = 1'b1; ex_dst = 4'd5; id_rs1 = 4'd5; id_use1 = 1'b1;
    steps(1);
    ex_load = 1'b0;
    steps(1);
    // Register 0 never hazards
    idle(); ex_load = 1'b1; ex_dst = 4'd0; id_rs1 = 4'd0; id_use1 = 1'b1;
    steps(1);
    // Branch redirect
    idle(); id_branch = 1'b1;
    steps(1);
    idle();
    steps(1);

    // Interrupt entry, drain, vector; repeat request while disabled
    acks = 0;
    id_pc_plus_4 = 32'h0000_0104; int_req = 1'b1;
    steps(1);
    int_req = 1'b0;
    steps(8);
    int_req = 1'b1;
    steps(8);
    check("ack_cnt_single", 32'(acks), 32'd1);
    check("epc_0x104", epc, 32'h0000_0104);
    idle(); id_reti = 1'b1;
    steps(1);
    idle();
    steps(2);

    // Interrupt with concurrent hazard: stall first, entry next cycle
    acks = 0;
    int_req = 1'b1;
    steps(1);
    int_req = 1'b0; ex_load = 1'b1; ex_dst = 4'd3; id_rs2 = 4'd3; id_use2 = 1'b1;
    id_pc_plus_4 = 32'h0000_0200;
    steps(1);
    idle(); id_pc_plus_4 = 32'h0000_0300;
    steps(D + 3);
    check("ack_cnt_hazard", 32'(acks), 32'd1);
    check("epc_after_stall", epc, 32'h0000_0300);
    id_reti = 1'b1;
    steps(1);
    idle();
    steps(1);

    // Reset in 2nd drain cycle abandons entry
    acks = 0;
    int_req = 1'b1;
    steps(1);
    int_req = 1'b0; id_pc_plus_4 = 32'h0000_0444;
    steps(2);
    rst = 1'b1;
    steps(1);
    rst = 1'b0;
    steps(6);
    check("ack_cnt_rst", 32'(acks), 32'd0);
    check("epc_rst", epc, 32'd0);
    int_req = 1'b1;
    steps(1);
    int_req = 1'b0;
    steps(D + 3);
    check("ack_cnt_reen", 32'(acks), 32'd1);
    idle(); id_reti = 1'b1;
    steps(1);

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      ex_load      = ($urandom_range(0, 2) == 0);
      ex_dst       = 4'($urandom_range(0, 7));
      id_rs1       = 4'($urandom_range(0, 7));
      id_rs2       = 4'($urandom_range(0, 7));
      id_use1      = 1'($urandom_range(0, 1));
      id_use2      = 1'($urandom_range(0, 1));
      id_branch    = ($urandom_range(0, 4) == 0);
      id_reti      = ($urandom_range(0, 9) == 0);
      int_req      = ($urandom_range(0, 7) == 0);
      id_pc_plus_4 = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYC, default 3, number of cycles spent draining the pipeline before interrupt vectoring (range 1..7).
REQ-002 Parameter INT_VEC, default 32'h0000_0010, interrupt handler address.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 id_rs1, id_rs2  input  4 each  source register fields of the instruction currently in ID.
REQ-006 id_use1, id_use2  input  1 each  ID instruction reads id_rs1 / id_rs2.
REQ-007 id_branch  input  1  ID branch taken (branch_sel from the decode stage).
REQ-008 id_reti  input  1  ID instruction is return-from-interrupt.
REQ-009 id_pc_plus_4  input  32  PC+4 of the ID instruction.
REQ-010 ex_load, ex_dst  input  1, 4  EX instruction is a load, and its destination register.
REQ-011 int_req  input  1  level interrupt request.
REQ-012 stall_pc, stall_if_id  output  1 each  hold the PC and the IF/ID register.
REQ-013 flush_if_id, flush_id_ex  output  1 each  insert a bubble into IF/ID or ID/EX.
REQ-014 pc_sel  output  2  next-PC select: 0 seq, 1 branch, 2 INT_VEC, 3 epc.
REQ-015 epc  output  32  saved return address.
REQ-016 int_ack  output  1  one-cycle interrupt acknowledge.

Function
REQ-017 States: RUN, DRAIN, VECTOR; all outputs are registered or derived combinationally from the state and current inputs.
REQ-018 Load-use hazard: ex_load and ((id_use1 and id_rs1==ex_dst) or (id_use2 and id_rs2==ex_dst)).
REQ-019 Register 0 is never a hazard source.
REQ-020 RUN + hazard: stall_pc=1, stall_if_id=1, flush_id_ex=1, pc_sel=0 in that cycle; id_branch and id_reti are ignored in that cycle.
REQ-021 RUN, no hazard, id_branch: pc_sel=1 and flush_if_id=1 for that cycle only.
REQ-022 RUN, no hazard, id_reti: pc_sel=3, flush_if_id=1, int_en set to 1 on the next edge.
REQ-023 int_pend is set when int_req=1 and int_en=1; it is cleared on int_ack.
REQ-024 Interrupt entry: RUN, int_pend=1, no hazard, id_branch=0, id_reti=0 -> epc<=id_pc_plus_4, int_en<=0, cnt<=DRAIN_CYC-1, next state DRAIN.
REQ-025 DRAIN: stall_pc=1, flush_if_id=1, flush_id_ex=1; cnt decrements each cycle; cnt==0 -> VECTOR.
REQ-026 VECTOR (exactly one cycle): pc_sel=2, int_ack=1, flush_if_id=1 -> RUN.
REQ-027 An interrupt that arrives with id_branch or id_reti active is deferred to the first eligible RUN cycle.
REQ-028 Hazard and interrupt in the same cycle: the stall wins; entry is retried next cycle.
REQ-029 Latency from int_pend=1 (eligible) to int_ack is DRAIN_CYC+1 cycles.
REQ-030 int_req while int_en=0 is ignored; nested interrupts are not supported.
REQ-031 stall_pc and flush_if_id are never both driven by the hazard path.

Reset
REQ-032 rst=1 at an edge forces: state=RUN, cnt=0, int_pend=0, int_en=1, epc=0; all strobes are 0 and pc_sel=0 on the following cycle.
REQ-033 rst asserted mid-DRAIN or mid-VECTOR abandons the entry: no int_ack is produced and epc is cleared.

Structure
REQ-034 A shared package holds the state enum {RUN, DRAIN, VECTOR}, the pc_sel encodings PCSEL_SEQ/BR/VEC/EPC, and the register-index width (4).
REQ-035 Sub-module hazard_detect holds the purely combinational load-use compare; the FSM, counter and epc stay in pipe_ctrl.

Verification
REQ-036 ex_load=1, ex_dst=5, id_rs1=5, id_use1=1 -> one cycle of stall_pc=stall_if_id=flush_id_ex=1; next cycle (ex_load=0) all strobes are 0.
REQ-037 ex_dst=0, id_rs1=0, ex_load=1 -> no stall.
REQ-038 id_branch=1, no hazard -> pc_sel=1, flush_if_id=1 for one cycle.
REQ-039 int_req=1, id_pc_plus_4=0x104, DRAIN_CYC=3 -> 3 DRAIN cycles with flushes, then pc_sel=2 with int_ack=1 on the 4th cycle, epc=0x104; a second int_req before reti produces no ack.
REQ-040 int_req together with a hazard -> stall first, entry next cycle, epc taken from the then-current id_pc_plus_4.
REQ-041 rst pulsed in the 2nd DRAIN cycle -> RUN, int_ack never asserts, epc=0, int_en=1.
